branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Fetch-side branch predictor for the RISC-V core. It is the producer of predictions that the execute-stage branch comparator later resolves.
- Combines a direct-mapped branch history table (2-bit saturating counters) with a branch target buffer (BTB).
- IF stage looks up the PC combinationally. EX stage writes back the resolved outcome, which the block uses to update its tables and flag mispredictions.
- Keeps 32-bit branch and mispredict statistics counters.

Parameters:
- INDEX_BITS, 4, log2 of table entries (16 entries); index = pc[INDEX_BITS+1:2]
- TAG_BITS, 30-INDEX_BITS, tag width; tag = pc[31:INDEX_BITS+2]

Ports:
- CLK  input  1  clock; all state changes on posedge
- RST  input  1  synchronous active-high reset
- if_pc  input  32  fetch PC to predict
- pred_taken  output  1  predicted taken for if_pc
- pred_hit  output  1  BTB valid and tag match for if_pc
- pred_target  output  32  predicted next PC
- upd_valid  input  1  EX-stage resolve strobe, one cycle per instruction
- upd_isBtype  input  1  resolving instruction is a conditional branch
- upd_pc  input  32  PC of resolving instruction
- upd_taken  input  1  actual outcome from the branch comparator
- upd_target  input  32  actual branch target (pc+imm)
- upd_pred_taken  input  1  prediction made for this instruction at fetch (carried down the pipe)
- upd_pred_target  input  32  predicted next PC made at fetch
- mispredict  output  1  combinational; resolved branch disagrees with its prediction
- correct_pc  output  32  redirect PC when mispredict=1
- num_branches  output  32  count of resolved B-type instructions
- num_mispredicts  output  32  count of mispredicts

Behaviour:

Per-entry state:
- valid (1b), tag (TAG_BITS), target (32b), ctr (2b): 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T.

Reset (RST=1 at posedge):
- All valid=0, all ctr=01, tag/target=0.
- num_branches=0, num_mispredicts=0.
- Outputs after reset with no update: pred_hit=0, pred_taken=0, pred_target=if_pc+4.

Lookup (combinational, zero latency):
- Index the table with if_pc.
- pred_hit = valid & (tag == if_pc tag).
- pred_taken = pred_hit & ctr[1].
- pred_target = pred_taken ? target : if_pc+4 (32-bit wrap).

Misprediction check (combinational on the upd_* inputs):
- Let act = upd_taken ? upd_target : upd_pc+4.
- mispredict = upd_valid & upd_isBtype & ((upd_pred_taken != upd_taken) | (upd_taken & (upd_pred_target != upd_target))).
- correct_pc = act whenever upd_valid & upd_isBtype; otherwise upd_pc+4.

Table update (at posedge, only when upd_valid & upd_isBtype & !RST):
- Hit (valid and tag match), taken: ctr saturating increment (11 stays 11); target <= upd_target.
- Hit, not taken: ctr saturating decrement (00 stays 00).
- Miss, taken: allocate the entry (overwrite any existing entry). valid=1, tag=upd_pc tag, target=upd_target, ctr=10.
- Miss, not taken: no table change.
- If upd_valid=1 but upd_isBtype=0: no state change, no counting.

Statistics (at posedge, same enable as table update):
- num_branches += 1.
- num_mispredicts += mispredict.
- Both wrap modulo 2^32.

Simultaneous events:
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents (read-before-write); the update is visible the next cycle.
- RST asserted together with upd_valid: reset wins, no update.
- RST asserted mid-run clears all history immediately at that edge.

No X propagation:
- Outputs are defined every cycle regardless of upd_* values when upd_valid=0.

Test Plan:
1. Reset, then drive if_pc=0x00000040 -> pred_hit=0, pred_taken=0, pred_target=0x00000044; both counters 0.
2. Update pc=0x40 taken, target=0x100, pred_taken=0 -> mispredict=1, correct_pc=0x100. Next cycle: if_pc=0x40 gives pred_hit=1, pred_taken=1, pred_target=0x100; num_branches=1, num_mispredicts=1.
3. Three not-taken updates at pc=0x40 with ctr starting at 10 -> ctr 01, 00, 00 (saturates). pred_taken=0 after the first, pred_target=0x44. Then two taken updates -> ctr 01, 10, and pred_taken=1 again.
4. Aliasing: allocate pc=0x40, then resolve taken at pc=0x80 (same index, INDEX_BITS=4, different tag) -> entry replaced. if_pc=0x40 gives pred_hit=0; if_pc=0x80 gives pred_hit=1 with the new target.
5. Same-cycle lookup and update at 0x40 (first taken) -> pred_hit=0 that cycle, 1 the next cycle. upd_valid=1 with upd_isBtype=0 -> counters and table unchanged, mispredict=0.
6. Correct predict taken but wrong target (upd_pred_target=0x100, upd_target=0x200) -> mispredict=1, correct_pc=0x200. Then assert RST together with upd_valid -> all statistics 0 and pred_hit=0 afterwards.

Source files
------------

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped 2-bit counter table plus a BTB, updated from EX.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic        pred_hit,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic        upd_isBtype,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] correct_pc,
  output logic [31:0] num_branches,
  output logic [31:0] num_mispredicts
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [31:0]         target_d [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic [1:0]          ctr_d    [ENTRIES];

  logic [31:0] num_branches_q, num_branches_d;
  logic [31:0] num_mispredicts_q, num_mispredicts_d;

  logic [INDEX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_BITS-1:0]   if_tag, upd_tag;
  logic                  upd_en, upd_hit;
  logic [31:0]           upd_fallthru, upd_act;

  always_comb begin
    if_idx      = if_pc[INDEX_BITS+1:2];
    if_tag      = if_pc[31:INDEX_BITS+2];
    pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = pred_hit && ctr_q[if_idx][1];
    pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;
  end

  always_comb begin
    upd_idx      = upd_pc[INDEX_BITS+1:2];
    upd_tag      = upd_pc[31:INDEX_BITS+2];
    upd_en       = upd_valid & upd_isBtype;
    upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_fallthru = upd_pc + 32'd4;
    upd_act      = upd_taken ? upd_target : upd_fallthru;
    mispredict   = upd_en & ((upd_pred_taken != upd_taken) |
                             (upd_taken & (upd_pred_target != upd_target)));
    correct_pc   = upd_en ? upd_act : upd_fallthru;
  end

  always_comb begin
    valid_d           = valid_q;
    tag_d             = tag_q;
    target_d          = target_q;
    ctr_d             = ctr_q;
    num_branches_d    = num_branches_q;
    num_mispredicts_d = num_mispredicts_q;
    if (upd_en) begin
      num_branches_d = num_branches_q + 32'd1;
      if (mispredict) begin
        num_mispredicts_d = num_mispredicts_q + 32'd1;
      end
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          end
          target_d[upd_idx] = upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = upd_target;
        ctr_d[upd_idx]    = 2'b10;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      num_branches_q    <= '0;
      num_mispredicts_q <= '0;
    end else begin
      valid_q           <= valid_d;
      tag_q             <= tag_d;
      target_q          <= target_d;
      ctr_q             <= ctr_d;
      num_branches_q    <= num_branches_d;
      num_mispredicts_q <= num_mispredicts_d;
    end
  end

  always_comb begin
    num_branches    = num_branches_q;
    num_mispredicts = num_mispredicts_q;
  end

endmodule
